dmem_bus_bridge: RTL and testbench

Data-memory bridge sitting directly downstream of the processor's MEM stage data port. It accepts one load/store at a time from the DataMem_* interface, performs it on a req/ack external memory bus with variable wait states, and returns read data with a Ready handshake. Address-range checking and a bus timeout turn faulty accesses into error-tagged completions, so the pipeline never hangs.

---
 rtl/dmem_bus_bridge.sv | 138 +++++++++++++
 tb/tb_dmem_bus_bridge.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_bridge.sv
// Bridge from the MEM-stage DataMem_* port to a req/ack memory bus.
// Out-of-range addresses and bus timeouts complete with an error tag so the pipeline never stalls.
module dmem_bus_bridge #(
  parameter int unsigned TIMEOUT    = 16,
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_FFFF,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DataMem_access,
  input  logic        DataMem_RW,
  input  logic [31:0] DataMem_Address,
  input  logic [3:0]  DataMem_Select,
  input  logic [31:0] WriteDataMem,
  output logic [31:0] ReadDataMem,
  output logic        DataMem_Ready,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        err_clr,
  output logic        err_flag,
  output logic [31:0] err_addr
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_e;

  localparam logic [7:0]  WAIT_LAST  = 8'(TIMEOUT - 1);
  localparam logic [31:0] ADDR_SPAN  = ADDR_LIMIT - ADDR_BASE;

  state_e      state_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [3:0]  bus_be_q;
  logic [31:0] bus_wdata_q;
  logic [31:0] addr_q;
  logic [7:0]  wait_q;
  logic [31:0] rdata_q;
  logic        err_flag_q;
  logic [31:0] err_addr_q;

  logic        in_range;
  logic        range_err;
  logic        timeout_hit;
  logic        err_set;
  logic [31:0] err_addr_d;
  logic        ready;

  always_comb begin
    // Offset compare covers [BASE, LIMIT] without a constant-true lower bound when BASE is 0.
    in_range    = (DataMem_Address - ADDR_BASE) <= ADDR_SPAN;
    range_err   = (state_q == IDLE) && DataMem_access && !in_range;
    timeout_hit = (state_q == BUS) && !bus_ack && (wait_q == WAIT_LAST);
    err_set     = range_err || timeout_hit;
    err_addr_d  = (state_q == IDLE) ? DataMem_Address : addr_q;
    ready       = 1'b0;
    case (state_q)
      IDLE:    ready = !DataMem_access;
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      addr_q      <= '0;
      wait_q      <= '0;
      rdata_q     <= '0;
      err_flag_q  <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (DataMem_access) begin
            bus_we_q    <= DataMem_RW;
            bus_addr_q  <= {DataMem_Address[31:2], 2'b00};
            bus_be_q    <= DataMem_Select;
            bus_wdata_q <= WriteDataMem;
            addr_q      <= DataMem_Address;
            wait_q      <= '0;
            if (in_range) begin
              state_q   <= BUS;
              bus_req_q <= 1'b1;
            end else begin
              state_q <= DONE;
              if (!DataMem_RW) rdata_q <= ERR_DATA;
            end
          end
        end
        BUS: begin
          if (bus_ack) begin
            state_q   <= DONE;
            bus_req_q <= 1'b0;
            if (!bus_we_q) rdata_q <= bus_rdata;
          end else if (wait_q == WAIT_LAST) begin
            state_q   <= DONE;
            bus_req_q <= 1'b0;
            if (!bus_we_q) rdata_q <= ERR_DATA;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      // A new error outranks a same-cycle clear, and re-arms err_addr capture.
      if (err_set) begin
        err_flag_q <= 1'b1;
        if (!err_flag_q || err_clr) err_addr_q <= err_addr_d;
      end else if (err_clr) begin
        err_flag_q <= 1'b0;
      end
    end
  end

  assign ReadDataMem   = rdata_q;
  assign DataMem_Ready = ready;
  assign bus_req       = bus_req_q;
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_be        = bus_be_q;
  assign bus_wdata     = bus_wdata_q;
  assign err_flag      = err_flag_q;
  assign err_addr      = err_addr_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed scoreboard bench for dmem_bus_bridge with TIMEOUT = 4 and the default address window.
module tb_dmem_bus_bridge;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        rst;
  logic        DataMem_access;
  logic        DataMem_RW;
  logic [31:0] DataMem_Address;
  logic [3:0]  DataMem_Select;
  logic [31:0] WriteDataMem;
  logic [31:0] ReadDataMem;
  logic        DataMem_Ready;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        err_clr;
  logic        err_flag;
  logic [31:0] err_addr;

  dmem_bus_bridge #(
    .TIMEOUT   (TO),
    .ADDR_BASE (32'h0000_0000),
    .ADDR_LIMIT(32'h0000_FFFF),
    .ERR_DATA  (32'hDEAD_BEEF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .DataMem_access (DataMem_access),
    .DataMem_RW     (DataMem_RW),
    .DataMem_Address(DataMem_Address),
    .DataMem_Select (DataMem_Select),
    .WriteDataMem   (WriteDataMem),
    .ReadDataMem    (ReadDataMem),
    .DataMem_Ready  (DataMem_Ready),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_be         (bus_be),
    .bus_wdata      (bus_wdata),
    .bus_rdata      (bus_rdata),
    .bus_ack        (bus_ack),
    .err_clr        (err_clr),
    .err_flag       (err_flag),
    .err_addr       (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    int          reqs;
    logic        eflag;
    logic [31:0] eaddr;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] rd_m = '0;
  logic        ef_m = 1'b0;
  logic [31:0] ea_m = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // k = cycle (1-based after the request cycle) in which bus_ack is driven; 0 = never.
  task automatic do_access(input logic rw, input logic [31:0] addr, input logic [3:0] sel,
                           input logic [31:0] wd, input int k, input logic [31:0] rd,
                           input logic clr);
    exp_t e;
    exp_t got;
    logic in_rng;
    logic err;
    int   reqs;
    int   lat;
    in_rng = (addr <= 32'h0000_FFFF);
    err    = !in_rng || (k == 0) || (k > int'(TO));
    e.lat  = !in_rng ? 1 : (err ? int'(TO) + 1 : k + 1);
    e.reqs = !in_rng ? 0 : (err ? int'(TO) : k);
    if (!rw) rd_m = err ? 32'hDEAD_BEEF : rd;
    e.rdata = rd_m;
    if (err) begin
      if (!ef_m || clr) ea_m = addr;
      ef_m = 1'b1;
    end else if (clr) begin
      ef_m = 1'b0;
    end
    e.eflag = ef_m;
    e.eaddr = ea_m;
    sb.push_back(e);

    @(posedge clk); #1;
    DataMem_access  = 1'b1;
    DataMem_RW      = rw;
    DataMem_Address = addr;
    DataMem_Select  = sel;
    WriteDataMem    = wd;
    err_clr         = clr;
    @(negedge clk);
    check("ready_in_req_cycle", 32'(DataMem_Ready), 32'd0);

    reqs = 0;
    lat  = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clk); #1;
      err_clr   = 1'b0;
      bus_ack   = (k == n);
      bus_rdata = rd;
      @(negedge clk);
      if (bus_req) begin
        reqs++;
        check("bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
        check("bus_be",   32'(bus_be), 32'(sel));
        check("bus_we",   32'(bus_we), 32'(rw));
        check("bus_wdata", bus_wdata, wd);
      end
      if (DataMem_Ready) lat = n;
    end

    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      got = sb.pop_front();
      check("ready_latency", 32'(lat),  32'(got.lat));
      check("req_cycles",    32'(reqs), 32'(got.reqs));
      check("ReadDataMem",   ReadDataMem, got.rdata);
      check("err_flag",      32'(err_flag), 32'(got.eflag));
      check("err_addr",      err_addr, got.eaddr);
    end

    @(posedge clk); #1;
    DataMem_access = 1'b0;
    bus_ack        = 1'b0;
    @(negedge clk);
    check("ready_idle", 32'(DataMem_Ready), 32'd1);
    check("req_idle",   32'(bus_req), 32'd0);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    ef_m = 1'b0;
    @(negedge clk);
    check("err_flag_cleared", 32'(err_flag), 32'(ef_m));
    check("err_addr_kept",    err_addr, ea_m);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b0;
    DataMem_access  = 1'b0;
    DataMem_RW      = 1'b0;
    DataMem_Address = '0;
    DataMem_Select  = '0;
    WriteDataMem    = '0;
    bus_rdata       = '0;
    bus_ack         = 1'b0;
    err_clr         = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready",    32'(DataMem_Ready), 32'd1);
    check("rst_bus_req",  32'(bus_req), 32'd0);
    check("rst_bus_we",   32'(bus_we), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_rdata",    ReadDataMem, 32'd0);
    check("rst_err_flag", 32'(err_flag), 32'd0);
    check("rst_err_addr", err_addr, 32'd0);
    DataMem_access = 1'b1;
    #1;
    check("rst_ready_follows_access", 32'(DataMem_Ready), 32'd0);
    DataMem_access = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    do_access(1'b0, 32'h0000_0010, 4'hF, 32'h0,         1, 32'h1234_5678, 1'b0);
    do_access(1'b1, 32'h0000_0022, 4'b0011, 32'hA5A5_A5A5, 4, 32'h0BAD_0BAD, 1'b0);
    do_access(1'b0, 32'h0000_FFFF, 4'hF, 32'h0,         2, 32'h55AA_0FF0, 1'b0);
    do_access(1'b0, 32'h0001_0000, 4'hF, 32'h0,         0, 32'h0,         1'b0);
    pulse_clr();
    do_access(1'b0, 32'h0000_0040, 4'hF, 32'h0,         0, 32'h1111_2222, 1'b0);
    pulse_clr();
    do_access(1'b0, 32'h0000_0044, 4'hF, 32'h0,         4, 32'hCAFE_0001, 1'b0);
    do_access(1'b0, 32'h0002_0000, 4'hF, 32'h0,         0, 32'h0,         1'b0);
    do_access(1'b1, 32'hFFFF_FFF0, 4'hF, 32'h7777_7777, 0, 32'h0,         1'b0);
    do_access(1'b0, 32'h0003_0000, 4'hF, 32'h0,         0, 32'h0,         1'b1);

    // Asynchronous reset in the middle of a bus transfer
    @(posedge clk); #1;
    DataMem_access  = 1'b1;
    DataMem_RW      = 1'b0;
    DataMem_Address = 32'h0000_0050;
    DataMem_Select  = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midbus_req_before_rst", 32'(bus_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("midbus_req_dropped", 32'(bus_req), 32'd0);
    check("midbus_ready",       32'(DataMem_Ready), 32'd0);
    check("midbus_rdata",       ReadDataMem, 32'd0);
    check("midbus_err_flag",    32'(err_flag), 32'd0);
    check("midbus_err_addr",    err_addr, 32'd0);
    check("midbus_bus_addr",    bus_addr, 32'd0);
    check("midbus_bus_we",      32'(bus_we), 32'd0);
    DataMem_access = 1'b0;
    rd_m = '0;
    ef_m = 1'b0;
    ea_m = '0;
    #1;
    check("midbus_ready_idle",  32'(DataMem_Ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    do_access(1'b0, 32'h0000_0008, 4'hF, 32'h0,         2, 32'h0BAD_F00D, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
